// File: rtl/unified_mem_responder_pkg.sv
// Shared encodings for the unified memory responder: load/store funct3 values,
// responder FSM states and requester port ids.
package unified_mem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } mem_port_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: sub-word load extraction/extension, store
// byte enables with lane replication, and the misalign/illegal-funct3 flag.
module mem_lane_align
  import unified_mem_responder_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data,
  output logic        err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = raw_word[7:0];
    case (addr_lo)
      2'd1:    sel_byte = raw_word[15:8];
      2'd2:    sel_byte = raw_word[23:16];
      2'd3:    sel_byte = raw_word[31:24];
      default: sel_byte = raw_word[7:0];
    endcase
    sel_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
  end

  // Unsigned sizes (1xx) exist only for loads; 011 and 11x are never legal.
  always_comb begin
    err = 1'b0;
    case (funct3)
      3'b000:         err = 1'b0;
      3'b001:         err = addr_lo[0];
      3'b010:         err = |addr_lo;
      3'b100, 3'b101: err = we | (funct3[0] & addr_lo[0]);
      default:        err = 1'b1;
    endcase
  end

  always_comb begin
    load_data = '0;
    if (!err) begin
      case (funct3)
        F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
        F3_LBU:  load_data = {24'b0, sel_byte};
        F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
        F3_LHU:  load_data = {16'b0, sel_half};
        F3_LW:   load_data = raw_word;
        default: load_data = '0;
      endcase
    end
  end

  always_comb begin
    byte_en    = '0;
    store_data = wdata;
    case (funct3[1:0])
      2'b00:   store_data = {4{wdata[7:0]}};
      2'b01:   store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
    if (we && !err) begin
      case (funct3[1:0])
        2'b00:   byte_en = 4'b0001 << addr_lo;
        2'b01:   byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        default: byte_en = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/unified_mem_responder.sv
// Single-ported byte-addressed memory serving fetch and data ports with fixed
// latency and alternating arbitration. MEM_TEXT_PROTECT_EN blocks text stores.
module unified_mem_responder
  import unified_mem_responder_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int LATENCY    = 2,
  parameter int TEXT_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err
);

  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef MEM_TEXT_PROTECT_EN
  localparam bit PROTECT_EN = 1'b1;
`else
  localparam bit PROTECT_EN = 1'b0;
`endif

  mem_state_t        state;
  mem_port_t         last_grant;
  mem_port_t         lat_port;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [2:0]        lat_f3;
  logic [31:0]       lat_wdata;

  logic [31:0] mem [WORDS];
  logic [31:0] raw_word;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic [3:0]  byte_en;
  logic        align_err;
  logic        in_text;
  logic        prot_err;
  logic        bad;
  logic        commit;

  assign raw_word = mem[lat_addr[ADDR_W-1:2]];

  mem_lane_align u_lane_align (
    .we         (lat_we),
    .funct3     (lat_f3),
    .addr_lo    (lat_addr[1:0]),
    .raw_word   (raw_word),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .byte_en    (byte_en),
    .store_data (store_data),
    .err        (align_err)
  );

  assign in_text  = 32'(lat_addr) < 32'(TEXT_BYTES);
  assign prot_err = PROTECT_EN & lat_we & in_text;
  assign bad      = align_err | prot_err;
  // The store lands on the same edge that moves the FSM into RESP.
  assign commit   = (state == MEM_WAIT) && (wait_cnt == '0) && lat_we && !bad;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst && state == MEM_IDLE) begin
      if (if_req && (!d_req || last_grant == PORT_D)) if_gnt = 1'b1;
      else if (d_req)                                  d_gnt  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MEM_IDLE;
      last_grant <= PORT_D;
      lat_port   <= PORT_IF;
      wait_cnt   <= '0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_f3     <= '0;
      lat_wdata  <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (if_gnt || d_gnt) begin
            state      <= MEM_WAIT;
            wait_cnt   <= CNT_W'(LATENCY - 1);
            lat_port   <= if_gnt ? PORT_IF : PORT_D;
            last_grant <= if_gnt ? PORT_IF : PORT_D;
            lat_addr   <= if_gnt ? if_addr : d_addr;
            lat_we     <= d_gnt & d_we;
            lat_f3     <= if_gnt ? F3_LW : d_funct3;
            lat_wdata  <= d_wdata;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt == '0) begin
            state <= MEM_RESP;
            if (lat_port == PORT_IF) begin
              if_rvalid <= 1'b1;
              if_err    <= bad;
              if_rdata  <= load_data;
            end else begin
              d_rvalid <= 1'b1;
              d_err    <= bad;
              d_rdata  <= lat_we ? 32'h0 : load_data;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        MEM_RESP: state <= MEM_IDLE;
        default:  state <= MEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[lat_addr[ADDR_W-1:2]][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Bench for unified_mem_responder: directed cases plus randomized traffic on
// both ports against a byte-array reference model with a response scoreboard.
module tb_unified_mem_responder;

  localparam int ADDR_W     = 12;
  localparam int LATENCY    = 2;
  localparam int TEXT_BYTES = 1024;
`ifdef MEM_TEXT_PROTECT_EN
  localparam logic [11:0] BASE = 12'h400;
`else
  localparam logic [11:0] BASE = 12'h000;
`endif

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [11:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]  d_funct3;
  logic [11:0] d_addr;
  logic [31:0] d_wdata, d_rdata;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: byte array plus per-byte "has been written" flags.
  logic [7:0]  model_mem [4096];
  bit          known     [4096];
  logic [64:0] if_exp_q[$];
  logic [64:0] d_exp_q[$];
  int          gnt_log[$];
  logic [64:0] e_if, e_d;
  bit          if_rv_q, d_rv_q;

  unified_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .TEXT_BYTES(TEXT_BYTES)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Returns {err, compare_mask, data} for one access and applies stores.
  function automatic logic [64:0] model_access(input bit is_if, input bit we,
      input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd);
    int size;
    bit sgn, bad;
    logic [31:0] v, m;
    int ai;
    ai = int'(a);
    size = 4; sgn = 0; bad = 0;
    if (!is_if && we) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: bad = 1;
      endcase
    end else if (!is_if) begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: bad = 1;
      endcase
    end
    if (ai % size != 0) bad = 1;
`ifdef MEM_TEXT_PROTECT_EN
    if (!is_if && we && ai < TEXT_BYTES) bad = 1;
`endif
    if (bad) return {1'b1, 32'hFFFF_FFFF, 32'h0};
    if (!is_if && we) begin
      for (int i = 0; i < size; i++) begin
        model_mem[ai+i] = wd[8*i +: 8];
        known[ai+i] = 1;
      end
      return {1'b0, 32'hFFFF_FFFF, 32'h0};
    end
    v = 0; m = 0;
    for (int i = 0; i < size; i++) begin
      v[8*i +: 8] = model_mem[ai+i];
      if (known[ai+i]) m[8*i +: 8] = 8'hFF;
    end
    for (int i = size; i < 4; i++) begin
      v[8*i +: 8] = (sgn && v[8*size-1]) ? 8'hFF : 8'h00;
      m[8*i +: 8] = (!sgn || known[ai+size-1]) ? 8'hFF : 8'h00;
    end
    return {1'b0, m, v};
  endfunction

  // driver tasks
  task automatic d_access(input bit we, input logic [2:0] f3, input logic [11:0] a,
      input logic [31:0] wd, output logic [31:0] rd, output logic er, output int gwait);
    int n;
    rd = '0; er = 1'b0;
    @(posedge clk); #1;
    d_req = 1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    gwait = 0;
    @(negedge clk);
    while (!d_gnt && gwait < 60) begin gwait++; @(negedge clk); end
    if (!d_gnt) begin
      check("d_gnt_timeout", 32'(gwait), 0);
      @(posedge clk); #1; d_req = 0;
    end else begin
      d_exp_q.push_back(model_access(0, we, f3, a, wd));
      @(posedge clk); #1;
      d_req = 0; d_addr = 12'($urandom); d_wdata = $urandom; d_funct3 = 3'($urandom); d_we = 1'($urandom);
      n = 1;
      @(negedge clk);
      while (!d_rvalid && n < 60) begin n++; @(negedge clk); end
      check("d_latency", 32'(n), LATENCY + 1);
      rd = d_rdata; er = d_err;
    end
  endtask

  task automatic if_access(input logic [11:0] a, output logic [31:0] rd, output logic er, output int gwait);
    int n;
    rd = '0; er = 1'b0;
    @(posedge clk); #1;
    if_req = 1; if_addr = a;
    gwait = 0;
    @(negedge clk);
    while (!if_gnt && gwait < 60) begin gwait++; @(negedge clk); end
    if (!if_gnt) begin
      check("if_gnt_timeout", 32'(gwait), 0);
      @(posedge clk); #1; if_req = 0;
    end else begin
      if_exp_q.push_back(model_access(1, 0, 3'b010, a, 32'h0));
      @(posedge clk); #1;
      if_req = 0; if_addr = 12'($urandom);
      n = 1;
      @(negedge clk);
      while (!if_rvalid && n < 60) begin n++; @(negedge clk); end
      check("if_latency", 32'(n), LATENCY + 1);
      rd = if_rdata; er = if_err;
    end
  endtask

  function automatic logic [11:0] rand_addr();
    logic [11:0] a;
    a = 12'h400 + 12'($urandom_range(0, 15) << 2);
    if ($urandom_range(0, 1) == 1) a = a + 12'($urandom_range(0, 3));
    return a;
  endfunction

  // scoreboard / protocol monitor
  always @(negedge clk) begin
    if (!rst) begin
      check("protocol", {26'b0, if_gnt & ~if_req, d_gnt & ~d_req, if_gnt & d_gnt,
                         if_rvalid & if_rv_q, d_rvalid & d_rv_q, if_rvalid & d_rvalid}, 32'h0);
      if (if_gnt) gnt_log.push_back(0);
      if (d_gnt)  gnt_log.push_back(1);
      if (d_rvalid) begin
        if (d_exp_q.size() == 0) check("d_unexpected_rvalid", 32'h1, 32'h0);
        else begin
          e_d = d_exp_q.pop_front();
          check("d_rdata", d_rdata & e_d[63:32], e_d[31:0] & e_d[63:32]);
          check("d_err", 32'(d_err), 32'(e_d[64]));
        end
      end
      if (if_rvalid) begin
        if (if_exp_q.size() == 0) check("if_unexpected_rvalid", 32'h1, 32'h0);
        else begin
          e_if = if_exp_q.pop_front();
          check("if_rdata", if_rdata & e_if[63:32], e_if[31:0] & e_if[63:32]);
          check("if_err", 32'(if_err), 32'(e_if[64]));
        end
      end
    end
    if_rv_q = if_rvalid;
    d_rv_q  = d_rvalid;
  end

  logic [31:0] rd, rd2;
  logic        er, er2;
  int          gw, gw2;

  initial begin
    clk = 0; rst = 1;
    if_req = 1; if_addr = '0;
    d_req = 1; d_we = 0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 4096; i++) begin model_mem[i] = 8'h00; known[i] = 0; end

    repeat (2) @(negedge clk);
    check("rst_flags", {26'b0, if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err}, 32'h0);
    check("rst_rdata", if_rdata | d_rdata, 32'h0);
    @(posedge clk); #1;
    if_req = 0; d_req = 0; rst = 0;

    // latency and back-to-back grant from IDLE
    d_access(1, 3'b010, BASE + 12'h100, 32'hDEAD_BEEF, rd, er, gw);
    check("first_gnt_wait", 32'(gw), 0);
    d_access(0, 3'b000, BASE + 12'h101, 32'h0, rd, er, gw);
    check("next_gnt_wait", 32'(gw), 0);
    check("lb_101", rd, 32'hFFFF_FFBE);
    d_access(0, 3'b100, BASE + 12'h103, 32'h0, rd, er, gw);
    check("lbu_103", rd, 32'h0000_00DE);
    d_access(0, 3'b001, BASE + 12'h102, 32'h0, rd, er, gw);
    check("lh_102", rd, 32'hFFFF_DEAD);
    d_access(0, 3'b101, BASE + 12'h100, 32'h0, rd, er, gw);
    check("lhu_100", rd, 32'h0000_BEEF);

    d_access(1, 3'b000, BASE + 12'h102, 32'h1234_5678, rd, er, gw);
    d_access(0, 3'b010, BASE + 12'h100, 32'h0, rd, er, gw);
    check("sb_merge", rd, 32'hDE78_BEEF);

    d_access(0, 3'b010, BASE + 12'h102, 32'h0, rd, er, gw);
    check("lw_mis_err", 32'(er), 32'h1);
    check("lw_mis_rdata", rd, 32'h0);
    d_access(1, 3'b001, BASE + 12'h101, 32'hAAAA_5555, rd, er, gw);
    check("sh_mis_err", 32'(er), 32'h1);
    d_access(0, 3'b010, BASE + 12'h100, 32'h0, rd, er, gw);
    check("sh_mis_nowrite", rd, 32'hDE78_BEEF);
    if_access(12'h006, rd, er, gw);
    check("if_mis_err", 32'(er), 32'h1);
    check("if_mis_rdata", rd, 32'h0);
    d_access(0, 3'b011, BASE + 12'h100, 32'h0, rd, er, gw);
    check("ld_f3_011_err", 32'(er), 32'h1);
    d_access(1, 3'b100, BASE + 12'h100, 32'h0, rd, er, gw);
    check("st_f3_100_err", 32'(er), 32'h1);

`ifdef MEM_TEXT_PROTECT_EN
    d_access(1, 3'b010, 12'h010, 32'h1111_2222, rd, er, gw);
    check("text_protect_err", 32'(er), 32'h1);
`endif

    // reset while a store is in WAIT: no rvalid, no write
    d_access(1, 3'b010, BASE + 12'h200, 32'hCAFE_F00D, rd, er, gw);
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_funct3 = 3'b010; d_addr = BASE + 12'h200; d_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("abort_gnt", 32'(d_gnt), 32'h1);
    @(posedge clk); #1; d_req = 0;
    @(posedge clk); #1; rst = 1; if_req = 1; d_req = 1;
    @(negedge clk);
    check("midrst_flags", {26'b0, if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err}, 32'h0);
    check("midrst_rdata", if_rdata | d_rdata, 32'h0);
    @(posedge clk); #1;
    if_req = 0; d_req = 0; rst = 0;
    gnt_log.delete();

    // arbitration from reset with both ports contending
    fork
      begin
        if_access(BASE + 12'h100, rd2, er2, gw2);
        if_access(BASE + 12'h104, rd2, er2, gw2);
      end
      begin
        d_access(0, 3'b010, BASE + 12'h200, 32'h0, rd, er, gw);
      end
    join
    check("arb_count", 32'(gnt_log.size()), 32'd3);
    if (gnt_log.size() >= 3)
      check("arb_order", 32'(gnt_log[0] * 4 + gnt_log[1] * 2 + gnt_log[2]), 32'b010);
    check("rst_no_write", rd, 32'hCAFE_F00D);

    // randomized traffic in a preloaded window
    for (int i = 0; i < 16; i++)
      d_access(1, 3'b010, 12'h400 + 12'(i * 4), $urandom, rd, er, gw);
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0: d_access(1'($urandom), 3'($urandom_range(0, 7)), rand_addr(), $urandom, rd, er, gw);
        1: if_access(rand_addr(), rd2, er2, gw2);
        default: fork
          d_access(1'($urandom), 3'($urandom_range(0, 7)), rand_addr(), $urandom, rd, er, gw);
          if_access(rand_addr(), rd2, er2, gw2);
        join
      endcase
    end

    repeat (6) @(negedge clk);
    check("d_q_drained", 32'(d_exp_q.size()), 32'h0);
    check("if_q_drained", 32'(if_exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
